// File: rtl/lfsr_word_arb_if.sv
// Bundle between the word arbiter, its requesters/consumers and the shared bit-serial LFSR.
// slave: the arbiter's view; master: the surrounding requesters and LFSR.
interface lfsr_word_arb_if #(
    parameter int NREQ = 4,
    parameter int WORD = 8
);
    logic [NREQ-1:0] req__ENA;
    logic [NREQ-1:0] req__RDY;
    logic [NREQ-1:0] rsp__ENA;
    logic [WORD-1:0] rsp_word;
    logic [NREQ-1:0] rsp__RDY;
    logic            shiftBit__ENA;
    logic            shiftBit_v;
    logic            shiftBit__RDY;
    logic            outBit;
    logic            outBit__RDY;

    modport slave (
        input  req__ENA, rsp__RDY, shiftBit__RDY, outBit, outBit__RDY,
        output req__RDY, rsp__ENA, rsp_word, shiftBit__ENA, shiftBit_v
    );

    modport master (
        output req__ENA, rsp__RDY, shiftBit__RDY, outBit, outBit__RDY,
        input  req__RDY, rsp__ENA, rsp_word, shiftBit__ENA, shiftBit_v
    );
endinterface

// File: rtl/lfsr_word_arb.sv
// Round-robin arbiter sharing one bit-serial LFSR among NREQ requesters; each grant
// clocks the LFSR WORD times and returns the collected bits MSB-first.
module lfsr_word_arb #(
    parameter int NREQ = 4,
    parameter int WORD = 8
) (
    input  logic           CLK,
    input  logic           RST,
    lfsr_word_arb_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WORD + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t          state, stateNext;
    logic [PW-1:0]   ptr, ptrNext;
    logic [PW-1:0]   owner, ownerNext;
    logic [CW-1:0]   cnt, cntNext;
    logic [WORD-1:0] word, wordNext;
    logic [NREQ-1:0] reqRdy, rspEna;
    logic            shiftEna, reqHit, rspHit;

    function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Ready and response enables decode registered state only, never the inputs.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqRdy[i] = (state == IDLE) && (ptr == PW'(i));
            rspEna[i] = (state == RESP) && (owner == PW'(i));
        end
    end

    assign shiftEna = (state == SHIFT) && bus.shiftBit__RDY && bus.outBit__RDY;
    assign reqHit   = |(bus.req__ENA & reqRdy);
    assign rspHit   = |(bus.rsp__RDY & rspEna);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        stateNext = state;
        ptrNext   = ptr;
        ownerNext = owner;
        cntNext   = cnt;
        wordNext  = word;
        unique case (state)
            IDLE: begin
                if (reqHit) begin
                    ownerNext = ptr;
                    cntNext   = '0;
                    wordNext  = '0;
                    stateNext = SHIFT;
                end else begin
                    ptrNext = wrapInc(ptr);
                end
            end
            SHIFT: begin
                if (shiftEna) begin
                    wordNext = {word[WORD-2:0], bus.outBit};
                    cntNext  = cnt + CW'(1);
                    if (cnt == CNT_LAST) stateNext = RESP;
                end
            end
            RESP: begin
                // Last winner drops to lowest priority.
                if (rspHit) begin
                    ptrNext   = wrapInc(owner);
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            word  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates together at the edge.
            state <= stateNext;
            ptr   <= ptrNext;
            owner <= ownerNext;
            cnt   <= cntNext;
            word  <= wordNext;
        end
    end

    assign bus.req__RDY      = reqRdy;
    assign bus.rsp__ENA      = rspEna;
    assign bus.rsp_word      = word;
    assign bus.shiftBit__ENA = shiftEna;
    assign bus.shiftBit_v    = 1'b0;
endmodule

// File: tb/tb_lfsr_word_arb.sv
// Self-checking bench: NREQ=4/WORD=8 instance against a transaction-level model with an
// external Galois LFSR, plus an NREQ=3/WORD=2 instance for pointer wrap.
module tb_lfsr_word_arb;
    localparam int NREQ4 = 4;
    localparam int WORD4 = 8;
    localparam logic [7:0] TAPS = 8'h45;

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    lfsr_word_arb_if #(.NREQ(4), .WORD(8)) a ();
    lfsr_word_arb_if #(.NREQ(3), .WORD(2)) b ();

    lfsr_word_arb #(.NREQ(4), .WORD(8)) dut4 (.CLK(clk), .RST(rst4), .bus(a));
    lfsr_word_arb #(.NREQ(3), .WORD(2)) dut3 (.CLK(clk), .RST(rst3), .bus(b));

    logic [3:0] want4 = '0;
    logic [2:0] want3 = '0;
    logic [7:0] lfsr4 = 8'h01;
    logic [7:0] lfsr3 = 8'h01;

    // Requesters only raise ENA while offered a slot.
    assign a.req__ENA = want4 & a.req__RDY;
    assign b.req__ENA = want3 & b.req__RDY;
    assign a.outBit   = lfsr4[0];
    assign b.outBit   = lfsr3[0];

    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // The n pre-shift output bits starting from state s, first bit ends up most significant.
    function automatic logic [7:0] lfsrWord(input logic [7:0] s, input int n);
        logic [7:0] w = '0;
        logic [7:0] st = s;
        for (int k = 0; k < n; k++) begin
            w  = {w[6:0], st[0]};
            st = lfsrStep(st);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (a.shiftBit__ENA) lfsr4 <= lfsrStep(lfsr4);
        if (b.shiftBit__ENA) lfsr3 <= lfsrStep(lfsr3);
    end

    int nCmp = 0;
    int nErr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         owner;
        int         cyc;
        logic [7:0] word;
    } ev_t;
    ev_t grantQ[$];
    ev_t rspQ[$];

    // Reference model for the 4-requester instance: who is offered, who is shifting, who answers.
    bit         mBusy = 0;
    bit         mResp = 0;
    int         mPtr = 0;
    int         mOwner = 0;
    int         mLeft = 0;
    logic [7:0] mWord = '0;
    int         shiftCnt4 = 0;

    always @(negedge clk) begin
        logic [3:0] expRdy;
        logic [3:0] expRspEna;
        logic       expShift;
        ev_t        e;
        assert ((a.req__ENA & ~a.req__RDY) == '0) else $error("protocol: req without rdy (4)");
        assert ((b.req__ENA & ~b.req__RDY) == '0) else $error("protocol: req without rdy (3)");
        if (rst4) begin
            mBusy = 0;
            mResp = 0;
            mPtr  = 0;
        end
        expRdy    = '0;
        expRspEna = '0;
        if (!mBusy) expRdy[mPtr] = 1'b1;
        if (mResp) expRspEna[mOwner] = 1'b1;
        expShift = mBusy && !mResp && a.shiftBit__RDY && a.outBit__RDY;
        check("m_req_rdy", 32'(a.req__RDY), 32'(expRdy));
        check("m_rsp_ena", 32'(a.rsp__ENA), 32'(expRspEna));
        check("m_shift_ena", 32'(a.shiftBit__ENA), 32'(expShift));
        check("m_shift_v", 32'(a.shiftBit_v), 32'd0);
        check("m_shift_v3", 32'(b.shiftBit_v), 32'd0);
        if (mResp) check("m_rsp_word", 32'(a.rsp_word), 32'(mWord));
        if (rst4) check("m_rst_word", 32'(a.rsp_word), 32'd0);
        if (!rst4) begin
            if (!mBusy) begin
                if (want4[mPtr]) begin
                    mBusy  = 1;
                    mOwner = mPtr;
                    mLeft  = WORD4;
                    mWord  = lfsrWord(lfsr4, WORD4);
                    e.owner = mPtr; e.cyc = cyc; e.word = '0;
                    grantQ.push_back(e);
                end else begin
                    mPtr = (mPtr + 1) % NREQ4;
                end
            end else if (!mResp) begin
                if (expShift) begin
                    shiftCnt4++;
                    mLeft--;
                    if (mLeft == 0) mResp = 1;
                end
            end else if (a.rsp__RDY[mOwner]) begin
                e.owner = mOwner; e.cyc = cyc; e.word = a.rsp_word;
                rspQ.push_back(e);
                mBusy = 0;
                mResp = 0;
                mPtr  = (mOwner + 1) % NREQ4;
            end
        end
    end

    int relCyc = 0;

    task automatic reset4();
        @(posedge clk); #1;
        rst4  = 1'b1;
        want4 = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst4   = 1'b0;
        relCyc = cyc;
    endtask

    task automatic waitGrant(input int n);
        for (int k = 0; k < 200 && grantQ.size() < n; k++) begin
            @(posedge clk); #1;
        end
        check("grant_count", 32'(grantQ.size()), 32'(n));
    endtask

    task automatic waitRsp(input int n);
        for (int k = 0; k < 300 && rspQ.size() < n; k++) begin
            @(posedge clk); #1;
        end
        check("rsp_count", 32'(rspQ.size()), 32'(n));
    endtask

    typedef struct {
        logic [3:0] want;
        int         owner;
        int         waitCyc;
        logic [3:0] rdyAfter;
    } vec_t;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   rrOrder[5];
        int   g0, r0, s1, hold, rel3, nRsp, sh3, idx;
        logic [7:0] firstWord, exp3;
        int   gOwn[$];
        int   gCyc[$];

        vecs[0] = '{4'b0001, 0, 0, 4'b0010};
        vecs[1] = '{4'b0100, 2, 2, 4'b1000};
        vecs[2] = '{4'b1000, 3, 3, 4'b0001};
        vecs[3] = '{4'b0110, 1, 1, 4'b0100};
        vecs[4] = '{4'b1001, 0, 0, 4'b0010};
        vecs[5] = '{4'b1100, 2, 2, 4'b1000};
        rrOrder = '{0, 1, 2, 3, 0};

        a.shiftBit__RDY = 1'b1;
        a.outBit__RDY   = 1'b1;
        a.rsp__RDY      = '1;
        b.shiftBit__RDY = 1'b1;
        b.outBit__RDY   = 1'b1;
        b.rsp__RDY      = '1;

        repeat (3) @(negedge clk);
        check("rst_req_rdy", 32'(a.req__RDY), 32'h1);
        check("rst_rsp_ena", 32'(a.rsp__ENA), 32'h0);
        check("rst_shift_ena", 32'(a.shiftBit__ENA), 32'h0);
        check("rst_word", 32'(a.rsp_word), 32'h0);

        // Single transactions from reset: pointer scan, first grant, latency, pointer after response.
        for (int v = 0; v < 6; v++) begin
            reset4();
            check("tbl_rdy_release", 32'(a.req__RDY), 32'h1);
            want4 = vecs[v].want;
            g0 = grantQ.size();
            r0 = rspQ.size();
            waitGrant(g0 + 1);
            want4 = '0;
            waitRsp(r0 + 1);
            if (grantQ.size() > g0 && rspQ.size() > r0) begin
                check("tbl_owner", grantQ[g0].owner, vecs[v].owner);
                check("tbl_wait", grantQ[g0].cyc - relCyc, vecs[v].waitCyc);
                check("tbl_latency", rspQ[r0].cyc - grantQ[g0].cyc, WORD4 + 1);
                check("tbl_rsp_owner", rspQ[r0].owner, vecs[v].owner);
            end
            check("tbl_rdy_after", 32'(a.req__RDY), 32'(vecs[v].rdyAfter));
        end

        // All four request continuously.
        reset4();
        want4 = '1;
        g0 = grantQ.size();
        r0 = rspQ.size();
        waitGrant(g0 + 5);
        want4 = '0;
        waitRsp(r0 + 5);
        if (grantQ.size() >= g0 + 5 && rspQ.size() >= r0 + 5) begin
            for (int k = 0; k < 5; k++) check("rr_owner", grantQ[g0 + k].owner, rrOrder[k]);
            for (int k = 0; k < 4; k++) begin
                check("rr_grant_gap", grantQ[g0 + k + 1].cyc - grantQ[g0 + k].cyc, WORD4 + 2);
                check("rr_rsp_gap", rspQ[r0 + k + 1].cyc - rspQ[r0 + k].cyc, WORD4 + 2);
            end
        end

        // Back-pressure on the LFSR and on the response; non-owner rsp__RDY bits are noise.
        reset4();
        want4 = 4'b0001;
        g0 = grantQ.size();
        r0 = rspQ.size();
        hold = 0;
        firstWord = '0;
        for (int k = 0; k < 300 && rspQ.size() == r0; k++) begin
            @(posedge clk); #1;
            if (grantQ.size() > g0) want4 = '0;
            a.shiftBit__RDY = 1'($urandom_range(0, 1));
            a.outBit__RDY   = 1'($urandom_range(0, 1));
            if (a.rsp__ENA != '0) begin
                if (hold == 0) firstWord = a.rsp_word;
                else check("bp_word_stable", 32'(a.rsp_word), 32'(firstWord));
                check("bp_ena_stable", 32'(a.rsp__ENA), 32'h1);
                hold++;
                a.rsp__RDY = {3'($urandom), hold > 5};
            end else begin
                a.rsp__RDY = {3'($urandom), 1'b0};
            end
        end
        check("bp_done", 32'(rspQ.size()), 32'(r0 + 1));
        check("bp_hold", hold, 6);
        if (rspQ.size() > r0) check("bp_word", 32'(rspQ[r0].word), 32'(firstWord));
        a.shiftBit__RDY = 1'b1;
        a.outBit__RDY   = 1'b1;
        a.rsp__RDY      = '1;

        // Asynchronous reset after three shifts; the partial word must vanish.
        reset4();
        want4 = 4'b0001;
        g0 = grantQ.size();
        waitGrant(g0 + 1);
        want4 = '0;
        s1 = shiftCnt4;
        for (int k = 0; k < 50 && shiftCnt4 - s1 < 3; k++) begin
            @(posedge clk); #1;
        end
        check("mid_shifts_before", shiftCnt4 - s1, 3);
        #1;
        rst4 = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(a.req__RDY), 32'h1);
        check("mid_rst_rsp_ena", 32'(a.rsp__ENA), 32'h0);
        check("mid_rst_shift_ena", 32'(a.shiftBit__ENA), 32'h0);
        check("mid_rst_word", 32'(a.rsp_word), 32'h0);
        r0 = rspQ.size();
        @(negedge clk);
        @(posedge clk); #1;
        rst4  = 1'b0;
        want4 = 4'b0001;
        g0 = grantQ.size();
        waitGrant(g0 + 1);
        want4 = '0;
        s1 = shiftCnt4;
        waitRsp(r0 + 1);
        check("mid_shifts_after", shiftCnt4 - s1, WORD4);
        if (rspQ.size() > r0 && grantQ.size() > g0)
            check("mid_latency", rspQ[r0].cyc - grantQ[g0].cyc, WORD4 + 1);

        // NREQ=3, WORD=2: requesters 1 and 2, pointer wraps 2 -> 0.
        @(posedge clk); #1;
        rst3  = 1'b0;
        want3 = 3'b110;
        rel3  = cyc;
        check("n3_rdy_release", 32'(b.req__RDY), 32'h1);
        nRsp = 0;
        sh3  = 0;
        exp3 = '0;
        for (int k = 0; k < 60 && nRsp < 3; k++) begin
            @(negedge clk);
            if (b.req__ENA != '0) begin
                idx = 0;
                for (int i = 0; i < 3; i++) if (b.req__ENA[i]) idx = i;
                gOwn.push_back(idx);
                gCyc.push_back(cyc - rel3);
                exp3 = lfsrWord(lfsr3, 2);
                sh3  = 0;
            end
            if (b.shiftBit__ENA) sh3++;
            if (b.rsp__ENA != '0 && gOwn.size() > 0) begin
                check("n3_rsp_ena", 32'(b.rsp__ENA), 32'(1) << gOwn[gOwn.size() - 1]);
                check("n3_rsp_word", 32'(b.rsp_word), 32'(exp3));
                check("n3_shifts", sh3, 2);
                nRsp++;
            end
        end
        want3 = '0;
        check("n3_rsp_total", nRsp, 3);
        check("n3_grant_total", 32'(gOwn.size()), 32'd3);
        if (gOwn.size() >= 3) begin
            check("n3_owner0", gOwn[0], 1);
            check("n3_owner1", gOwn[1], 2);
            check("n3_owner2", gOwn[2], 1);
            check("n3_cyc0", gCyc[0], 1);
            check("n3_cyc1", gCyc[1], 5);
            check("n3_cyc2", gCyc[2], 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/lfsr_word_arb.md
# lfsr_word_arb

Round-robin scheduler that shares one Galois LFSR instance (bit-serial `shiftBit`/`outBit` method pair) among `NREQ` requesters that each need a `WORD`-bit random word. It grants one requester at a time and clocks the LFSR `WORD` times, collecting `outBit` MSB-first. It returns the assembled word to the granted requester through a response method. It sits between the LFSR client modport and the consumer blocks (scramblers, test-pattern sources).

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥1; need not be a power of two.
- `WORD`, 8: bits per returned word, ≥2.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req__ENA`  in  NREQ  per-requester request method enable; bit i may be high only while `req__RDY[i]` is high.
- `req__RDY`  out  NREQ  per-requester request ready; at most one bit high.
- `rsp__ENA`  out  NREQ  one-hot response enable toward the owning requester.
- `rsp$word`  out  WORD  response word; valid while any `rsp__ENA` bit is high.
- `rsp__RDY`  in  NREQ  per-requester response ready.
- `shiftBit__ENA`  out  1  LFSR shift enable.
- `shiftBit$v`  out  1  LFSR shift-in value; constant 0.
- `shiftBit__RDY`  in  1  LFSR shift ready.
- `outBit`  in  1  current LFSR output bit.
- `outBit__RDY`  in  1  LFSR output valid.

## Operation
- State: `state` ∈ {IDLE, SHIFT, RESP}; `ptr`, the round-robin pointer (0..NREQ-1); `owner` (0..NREQ-1); `cnt` (0..WORD, width clog2(WORD+1)); `word` (WORD bits).
- `req__RDY[i]` = (state==IDLE) && (ptr==i). It depends only on registered state, not on any `req__ENA` input.
- IDLE:
  - `req__ENA[ptr]` high → `owner`←ptr, `cnt`←0, `word`←0, go to SHIFT.
  - `req__ENA[ptr]` low → `ptr`←(ptr+1) mod NREQ, with wrap from NREQ-1 to 0.
  - Each idle requester is therefore offered a slot every NREQ cycles.
- SHIFT:
  - `shiftBit__ENA` = `shiftBit__RDY && outBit__RDY`.
  - On a cycle where `shiftBit__ENA` is high: `word`←{word[WORD-2:0], outBit}, `cnt`←cnt+1. The sampled `outBit` is the LFSR output before that cycle's shift.
  - When `cnt` reaches WORD-1 on an enabled cycle, go to RESP.
  - Either ready low → stall: no shift, no sample, state held.
- RESP:
  - `rsp__ENA[owner]`=1, all other `rsp__ENA` bits 0; `rsp$word`=`word`, held stable.
  - When `rsp__RDY[owner]` is high, go to IDLE and set `ptr`←(owner+1) mod NREQ, so the last winner gets lowest priority.
  - `rsp__RDY` bits of non-owners are ignored.
- Outside RESP, `rsp$word` reflects `word` but is don't-care. `shiftBit$v` is always 0. `shiftBit__ENA` is 0 outside SHIFT.
- The block never issues `shiftBit__ENA` while `shiftBit__RDY` is low.
- Reset (asynchronous, any state):
  - state=IDLE, ptr=0, owner=0, cnt=0, word=0.
  - Outputs during and after reset: `req__RDY`=1 on bit 0 and 0 on all other bits; `rsp__ENA`=0; `rsp$word`=0; `shiftBit__ENA`=0; `shiftBit$v`=0.
  - A partially assembled word is discarded and no response is issued.
- Protocol violation (`req__ENA[i]` high while `req__RDY[i]` is low) is ignored and has no state effect. The bench flags it with an assertion.

## Timing
- Grant handshake at edge t → SHIFT from cycle t+1.
- With LFSR always ready: shifts occur at cycles t+1 … t+WORD; `rsp__ENA` is high from cycle t+WORD+1.
- A response accepted in cycle r → IDLE in cycle r+1, with `req__RDY` on (owner+1) mod NREQ.
- Minimum word period with back-to-back requesters: WORD+2 cycles.
- Latency from a requester raising `req__ENA` to its grant: at most NREQ-1 idle steps plus any in-progress transaction.
- All outputs are combinational functions of registered state, except `shiftBit__ENA`, which also depends on `shiftBit__RDY` and `outBit__RDY`. There are no combinational paths from `req__ENA` or `rsp__RDY` to any output.

## Test plan
- Reset and single request:
  - After RST, check `req__RDY`=4'b0001.
  - Requester 0 requests; LFSR model (8-bit, TAPS 45, seed 8'h01) always ready.
  - Expect exactly 8 `shiftBit__ENA` pulses, then `rsp__ENA`=4'b0001 at cycle t+9.
  - `rsp$word` equals the model's 8 pre-shift output bits, MSB first.
- Round robin:
  - Requesters 0–3 all request continuously.
  - Grants occur in order 0,1,2,3,0; each response is 10 cycles apart with `rsp__RDY` tied high.
- Pointer scan:
  - Only requester 2 requests, starting at reset release.
  - `req__RDY` steps 0→1→2; grant lands at the third cycle.
  - After the response, `req__RDY`=4'b1000.
- Back-pressure:
  - Toggle `shiftBit__RDY` and `outBit__RDY` pseudo-randomly; hold `rsp__RDY[owner]` low for 5 cycles.
  - Expect no ENA while ready is low, the word still matches the model, and `rsp$word`/`rsp__ENA` stable until acceptance.
- Reset mid-SHIFT:
  - Assert RST after 3 shifts, asynchronously mid-cycle.
  - Outputs return to reset values immediately; no `rsp__ENA` is ever seen; the next request produces a full 8-bit word.
- NREQ=3, WORD=2 build:
  - Requesters 1 and 2 request.
  - Pointer wraps 2→0; grants go 1,2,1; each response uses 2 shifts.
